seg7_scan: RTL
==============

Name: seg7_scan

Overview:
- Time-multiplexed scanner for an 8-digit common-anode 7-segment display.
- Sits directly upstream of the hex-to-segment decoder.
- Holds a 32-bit display word plus per-digit point/blank masks, and cycles one digit at a time.
- Drives the decoder's nibble, LE (active-low enable, 1 = blank) and point inputs, and drives the active-low digit anodes.
- Frame-synchronous update, so a digit never shows half-old/half-new data.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit; must be >= 2. Use 4 in simulation.
- CNT_W, 17: prescaler width; must satisfy 2^CNT_W >= SCAN_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- load  in  1  capture data_in/point_in/blank_in this cycle
- data_in  in  32  display word; digit k shows data_in[4k+3:4k]
- point_in  in  8  per-digit decimal point, active-high
- blank_in  in  8  per-digit blank, active-high
- hex  out  4  nibble to decoder {D3..D0}
- le  out  1  to decoder LE; 1 = segments off
- point  out  1  to decoder point, active-high
- an  out  8  digit anodes, active-low, one-hot-low
- frame_done  out  1  one-cycle pulse when the digit index wraps 7->0

Behaviour:
- State registers:
  - presc (CNT_W bits)
  - idx (3 bits)
  - shadow word/point/blank
  - pending flag
  - disp word/point/blank
- Reset: presc=0, idx=0, shadow=0, disp=0, pending=0.
  - Outputs after reset: an=8'hFF, hex=0, le=1, point=0, frame_done=0.
- Prescaler:
  - presc increments every cycle.
  - When presc==SCAN_DIV-1, it returns to 0 and tick=1 for that cycle.
- Digit advance: on tick, idx <= idx+1 (wraps 7->0).
- Load:
  - load=1 captures the inputs into shadow and sets pending=1.
  - Back-to-back loads overwrite shadow; the last one wins.
- Frame swap: on a tick with idx==7:
  - idx becomes 0.
  - If pending, disp <= shadow and pending <= 0.
  - frame_done=1 the following cycle, for exactly one cycle.
- Load on the swap cycle: load=1 coincident with the swap tick bypasses shadow.
  - disp <= inputs directly and pending stays 0.
  - The new data is never lost or delayed a frame.
- Output stage (registered, one cycle after idx/disp change):
  - an <= ~(8'b1 << idx)
  - hex <= disp_word[4*idx +: 4]
  - point <= disp_point[idx]
  - le <= disp_blank[idx]
- Exactly one an bit is low at any time after the first post-reset cycle.
- No blanking gap between digits.
- Latency: load at cycle n becomes visible starting with the first digit-0 output after the next frame swap. Worst case is 8*SCAN_DIV+1 cycles.
- Mid-frame load: remaining digits of the current frame still show the old disp.
- Reset mid-scan: all state returns to reset values on the next edge. Any pending load is discarded.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: digit k is blanked (le=1) when every nibble from digit k up to digit 7 of disp_word is zero, for k = 7 down to 1.
  - Digit 0 is never zero-blanked.
  - Still ORed with disp_blank.
  - point is unaffected.
- Undefined: le = disp_blank[idx] only.

Decomposition:
- Package seg7_pkg:
  - DIGITS=8
  - IDX_W=3
  - AN_OFF=8'hFF
  - display-record typedef {word[31:0], point[7:0], blank[7:0]} used for both shadow and disp
- One sub-module: seg7_prescaler (parameter SCAN_DIV; ports clk, rst, tick).

Test Plan (SCAN_DIV=4):
- Reset: assert rst for 3 cycles -> an=FF, le=1, hex=0, point=0, frame_done=0; the first tick arrives 4 cycles after rst deasserts.
- Basic frame: load 32'h12345678 once -> after the next swap, the digit sequence is an=FE/hex=8, FD/7, FB/6, F7/5, EF/4, DF/3, BF/2, 7F/1, each held 4 cycles; frame_done pulses once per 32 cycles.
- Tear check: load 32'hAAAAAAAA then 32'h55555555 while idx=3 -> digits 3..7 of the current frame still show the old data; the full 5s frame starts at digit 0; A's are never displayed.
- Coincident load: load 32'hDEADBEEF on the swap tick -> digit 0 shows hex=F in the next frame, pending=0.
- Masks: point_in=8'h04, blank_in=8'h80 -> point=1 only while an=FB; le=1 only while an=7F.
- Feature on: load 32'h000000A5 -> digits 0,1 show 5,A with le=0; digits 2..7 le=1; data 0 -> only digit 0 lit, showing 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants, display record and leading-zero helper for the 8-digit
// 7-segment scanner.
package seg7_pkg;

  localparam int         DIGITS = 8;
  localparam int         IDX_W  = 3;
  localparam logic [7:0] AN_OFF = 8'hFF;

  typedef struct packed {
    logic [31:0] word;
    logic [7:0]  point;
    logic [7:0]  blank;
  } disp_rec_t;

  // Bit k is set when nibbles k..7 are all zero; digit 0 is always kept lit.
  function automatic logic [DIGITS-1:0] lead_zero_mask(input logic [31:0] word);
    logic [DIGITS-1:0] m;
    logic              allz;
    m    = '0;
    allz = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      allz = allz & (word[4*k +: 4] == 4'h0);
      m[k] = allz;
    end
    return m;
  endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Digit-rate prescaler: tick is high for one cycle out of every SCAN_DIV,
// first tick SCAN_DIV cycles after reset releases.
module seg7_prescaler #(
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [CNT_W-1:0] presc;

  assign tick = (presc == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// 8-digit multiplexed display scanner with frame-synchronous update; outputs registered (1 cycle),
// no backpressure. SEG7_LEADING_ZERO_BLANK_EN enables leading-zero blanking.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] data_in,
  input  logic [7:0]  point_in,
  input  logic [7:0]  blank_in,
  output logic [3:0]  hex,
  output logic        le,
  output logic        point,
  output logic [7:0]  an,
  output logic        frame_done
);

  logic             tick;
  logic             swap;
  logic [IDX_W-1:0] idx;
  logic             pending;
  disp_rec_t        shadow;
  disp_rec_t        disp;
  disp_rec_t        in_rec;
  logic [DIGITS-1:0] lz;

  seg7_prescaler #(
    .SCAN_DIV (SCAN_DIV),
    .CNT_W    (CNT_W)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign in_rec = {data_in, point_in, blank_in};
  assign swap   = tick && (idx == IDX_W'(DIGITS - 1));

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  assign lz = lead_zero_mask(disp.word);
`else
  assign lz = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      pending    <= 1'b0;
      shadow     <= '0;
      disp       <= '0;
      frame_done <= 1'b0;
      an         <= AN_OFF;
      hex        <= 4'h0;
      le         <= 1'b1;
      point      <= 1'b0;
    end else begin
      frame_done <= swap;
      if (tick) begin
        idx <= idx + IDX_W'(1);
      end
      // A load landing on the swap tick goes straight to disp so it is not held a frame.
      if (load && swap) begin
        disp    <= in_rec;
        pending <= 1'b0;
      end else begin
        if (swap && pending) begin
          disp    <= shadow;
          pending <= 1'b0;
        end
        if (load) begin
          shadow  <= in_rec;
          pending <= 1'b1;
        end
      end
      an    <= ~(DIGITS'(1) << idx);
      hex   <= disp.word[4*idx +: 4];
      point <= disp.point[idx];
      le    <= disp.blank[idx] | lz[idx];
    end
  end

endmodule
